neighbor_min_seq: RTL and testbench

//  Sequential initiator for the min_select comparator in the maze search datapath.
//  For the current cell it walks the 4 neighbours in the order up, down, left, right.
//  It fetches each open neighbour's cost over a req/ack read port, then reduces the

---
 rtl/maze_pkg.sv | 18 +
 rtl/neighbor_addr_gen.sv | 30 +++
 rtl/neighbor_min_seq.sv | 134 +++++++++++++
 tb/tb_neighbor_min_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared direction codes, cost sentinel, plot helpers and search FSM states
package maze_pkg;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam logic [9:0] COST_INF  = 10'h3FF;
  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_REQ, ST_MERGE, ST_DONE} state_t;
  function automatic logic [9:0] plot_pack(input logic [4:0] y, input logic [4:0] x);
    return {y, x};
  endfunction
  function automatic logic [4:0] plot_y(input logic [9:0] p);
    return p[9:5];
  endfunction
  function automatic logic [4:0] plot_x(input logic [9:0] p);
    return p[4:0];
  endfunction
endpackage

// File: rtl/neighbor_addr_gen.sv
// neighbor_addr_gen: plot of the neighbour in direction dir and whether it lies off the grid
//   cur_plot in  {y,x} of the current cell
//   dir      in  DIR_UP/DOWN/LEFT/RIGHT
//   nb_plot  out {y,x} of the neighbour (wraps when off_grid; never used then)
//   off_grid out neighbour lies outside the MAZE_W x MAZE_H grid
module neighbor_addr_gen
  import maze_pkg::*;
#(
  parameter int MAZE_W = 32,
  parameter int MAZE_H = 32
) (
  input  logic [9:0] cur_plot,
  input  logic [1:0] dir,
  output logic [9:0] nb_plot,
  output logic       off_grid
);
  logic [4:0] x, y;
  always_comb begin
    y = plot_y(cur_plot);
    x = plot_x(cur_plot);
    off_grid = (dir == DIR_UP    && y == 5'd0) ||
               (dir == DIR_DOWN  && y == 5'(MAZE_H - 1)) ||
               (dir == DIR_LEFT  && x == 5'd0) ||
               (dir == DIR_RIGHT && x == 5'(MAZE_W - 1));
    nb_plot = dir == DIR_UP   ? plot_pack(y - 5'd1, x) :
              dir == DIR_DOWN ? plot_pack(y + 5'd1, x) :
              dir == DIR_LEFT ? plot_pack(y, x - 5'd1) :
                                plot_pack(y, x + 5'd1);
  end
endmodule

// File: rtl/neighbor_min_seq.sv
// neighbor_min_seq: walks the 4 neighbours of a cell, fetches costs and reduces them through min_select
//   m_clock/p_reset        clock, synchronous active-high reset
//   start/cur_plot/wall_mask  search request, latched in IDLE
//   busy                   search in progress
//   rd_req/rd_addr/rd_ack/rd_data  neighbour cost read port
//   cmp_*                  external min_select comparator (slot1 candidate, slot2 current best)
//   done/best_ene/best_plot/no_move  result, valid from done until next start
module neighbor_min_seq #(
  parameter int         MAZE_W   = 32,
  parameter int         MAZE_H   = 32,
  parameter logic [9:0] COST_INF = maze_pkg::COST_INF
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       start,
  input  logic [9:0] cur_plot,
  input  logic [3:0] wall_mask,
  output logic       busy,
  output logic       rd_req,
  output logic [9:0] rd_addr,
  input  logic       rd_ack,
  input  logic [9:0] rd_data,
  output logic       cmp_exe,
  output logic [9:0] cmp_ene1,
  output logic [9:0] cmp_ene2,
  output logic [9:0] cmp_plot1,
  output logic [9:0] cmp_plot2,
  input  logic [9:0] cmp_outene,
  input  logic [9:0] cmp_outplot,
  output logic       done,
  output logic [9:0] best_ene,
  output logic [9:0] best_plot,
  output logic       no_move
);
  import maze_pkg::*;
  state_t     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [9:0] cur_q, cur_d;
  logic [3:0] wall_q, wall_d;
  logic       have_q, have_d;
  logic [9:0] data_q, data_d;
  logic [9:0] best_ene_q, best_ene_d;
  logic [9:0] best_plot_q, best_plot_d;
  logic       no_move_q, no_move_d;
  logic [9:0] nb_plot;
  logic       off_grid;
  logic       last;
  neighbor_addr_gen #(.MAZE_W(MAZE_W), .MAZE_H(MAZE_H)) u_addr (
    .cur_plot(cur_q),
    .dir     (dir_q),
    .nb_plot (nb_plot),
    .off_grid(off_grid)
  );
  assign last      = dir_q == DIR_RIGHT;
  assign busy      = state_q != ST_IDLE;
  assign rd_req    = state_q == ST_REQ;
  assign rd_addr   = rd_req ? nb_plot : '0;
  // The comparator only runs once a best exists; the first valid candidate is loaded directly.
  assign cmp_exe   = state_q == ST_MERGE && have_q && data_q != COST_INF;
  assign cmp_ene1  = cmp_exe ? data_q : '0;
  assign cmp_plot1 = cmp_exe ? nb_plot : '0;
  assign cmp_ene2  = cmp_exe ? best_ene_q : '0;
  assign cmp_plot2 = cmp_exe ? best_plot_q : '0;
  assign done      = state_q == ST_DONE;
  assign best_ene  = best_ene_q;
  assign best_plot = best_plot_q;
  assign no_move   = no_move_q;
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cur_d       = cur_q;
    wall_d      = wall_q;
    have_d      = have_q;
    data_d      = data_q;
    best_ene_d  = best_ene_q;
    best_plot_d = best_plot_q;
    no_move_d   = no_move_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d     = ST_CHECK;
        cur_d       = cur_plot;
        wall_d      = wall_mask;
        dir_d       = DIR_UP;
        have_d      = 1'b0;
        best_ene_d  = '0;
        best_plot_d = '0;
        no_move_d   = 1'b0;
      end
      ST_CHECK: if (wall_q[dir_q] || off_grid) begin
        state_d = last ? ST_DONE : ST_CHECK;
        dir_d   = dir_q + 2'd1;
      end else state_d = ST_REQ;
      ST_REQ: if (rd_ack) begin
        data_d  = rd_data;
        state_d = ST_MERGE;
      end
      ST_MERGE: begin
        if (data_q != COST_INF) begin
          have_d      = 1'b1;
          best_ene_d  = have_q ? cmp_outene : data_q;
          best_plot_d = have_q ? cmp_outplot : nb_plot;
        end
        state_d = last ? ST_DONE : ST_CHECK;
        dir_d   = dir_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Best registers stay zero when nothing was loaded, so only the flag needs setting here.
    if (state_q != ST_DONE && state_d == ST_DONE) no_move_d = !have_d;
  end
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= '0;
      cur_q       <= '0;
      wall_q      <= '0;
      have_q      <= 1'b0;
      data_q      <= '0;
      best_ene_q  <= '0;
      best_plot_q <= '0;
      no_move_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_q       <= cur_d;
      wall_q      <= wall_d;
      have_q      <= have_d;
      data_q      <= data_d;
      best_ene_q  <= best_ene_d;
      best_plot_q <= best_plot_d;
      no_move_q   <= no_move_d;
    end
  end
endmodule

// File: tb/tb_neighbor_min_seq.sv
// tb_neighbor_min_seq: scoreboard bench for neighbor_min_seq with a behavioural min_select and cost memory
module tb_neighbor_min_seq;
  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] cur_plot = '0;
  logic [3:0] wall_mask = '0;
  logic       busy, rd_req, cmp_exe, done, no_move;
  logic [9:0] rd_addr, cmp_ene1, cmp_ene2, cmp_plot1, cmp_plot2, best_ene, best_plot;
  logic       rd_ack = 1'b0;
  logic [9:0] rd_data = '0;
  logic [9:0] cmp_outene, cmp_outplot;
  int n_tests = 0, n_fail = 0;
  int ack_delay = 0, ack_cnt = 0;
  int n_exe = 0, n_req = 0, n_done = 0;
  logic       pend = 1'b0;
  logic [9:0] held = '0;
  logic [9:0] mem [1024];
  typedef struct {
    logic [9:0] ene;
    logic [9:0] plot;
    logic       nm;
    int         lat;
  } exp_t;
  exp_t sb[$];

  neighbor_min_seq dut (
    .m_clock(m_clock), .p_reset(p_reset), .start(start), .cur_plot(cur_plot),
    .wall_mask(wall_mask), .busy(busy), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .cmp_exe(cmp_exe), .cmp_ene1(cmp_ene1),
    .cmp_ene2(cmp_ene2), .cmp_plot1(cmp_plot1), .cmp_plot2(cmp_plot2),
    .cmp_outene(cmp_outene), .cmp_outplot(cmp_outplot), .done(done),
    .best_ene(best_ene), .best_plot(best_plot), .no_move(no_move)
  );

  always #5 m_clock = ~m_clock;

  assign cmp_outene  = (cmp_ene1 < cmp_ene2) ? cmp_ene1 : cmp_ene2;
  assign cmp_outplot = (cmp_ene1 < cmp_ene2) ? cmp_plot1 : cmp_plot2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge m_clock) begin
    if (rd_req) n_req++;
    if (cmp_exe) n_exe++;
    if (done) n_done++;
    if (rd_req && !rd_ack) begin
      if (pend) check("rd_addr_hold", rd_addr, held);
      pend = 1'b1;
      held = rd_addr;
      if (ack_cnt == ack_delay) begin
        rd_ack  = 1'b1;
        rd_data = mem[rd_addr];
        ack_cnt = 0;
        pend    = 1'b0;
      end else ack_cnt++;
    end else begin
      rd_ack  = 1'b0;
      pend    = 1'b0;
      ack_cnt = 0;
    end
  end

  function automatic exp_t model(input logic [9:0] cur, input logic [3:0] w, input int dly);
    exp_t e;
    logic have;
    int y, x;
    have  = 1'b0;
    y     = int'(cur[9:5]);
    x     = int'(cur[4:0]);
    e.ene = '0;
    e.plot = '0;
    e.lat = 1;
    for (int d = 0; d < 4; d++) begin
      int ny, nx;
      logic off;
      logic [9:0] nb, c;
      ny = y + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0);
      nx = x + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
      off = ny < 0 || ny > 31 || nx < 0 || nx > 31;
      if (w[d] || off) e.lat += 1;
      else begin
        nb = {5'(ny), 5'(nx)};
        c  = mem[nb];
        e.lat += 3 + dly;
        if (c != 10'h3FF && (!have || c < e.ene)) begin
          e.ene  = c;
          e.plot = nb;
          have   = 1'b1;
        end
      end
    end
    e.nm = !have;
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 10'h3FF;
  endtask

  task automatic set_around(input logic [9:0] cur, input logic [9:0] u, input logic [9:0] dn,
                            input logic [9:0] l, input logic [9:0] r);
    logic [4:0] y, x;
    y = cur[9:5];
    x = cur[4:0];
    mem[{y - 5'd1, x}] = u;
    mem[{y + 5'd1, x}] = dn;
    mem[{y, x - 5'd1}] = l;
    mem[{y, x + 5'd1}] = r;
  endtask

  task automatic run(input logic [9:0] cur, input logic [3:0] w, input int dly, input int hold);
    exp_t e;
    int c;
    @(negedge m_clock);
    ack_delay = dly;
    cur_plot  = cur;
    wall_mask = w;
    start     = 1'b1;
    sb.push_back(model(cur, w, dly));
    @(negedge m_clock);
    c = 1;
    start    = hold > 0;
    cur_plot = ~cur;
    while (!done && c < 300) begin
      @(negedge m_clock);
      c++;
      start = c <= hold;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) check("done_timeout", 0, 1);
    else begin
      check("latency", c, e.lat);
      check("best_ene", best_ene, e.ene);
      check("best_plot", best_plot, e.plot);
      check("no_move", no_move, e.nm);
      check("busy_at_done", busy, 1);
    end
    @(negedge m_clock);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, d0, c;
    logic [9:0] cur;
    clear_mem();
    repeat (3) @(negedge m_clock);
    check("rst_busy", busy, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_cmp_exe", cmp_exe, 0);
    check("rst_cmp_ene1", cmp_ene1, 0);
    check("rst_done", done, 0);
    check("rst_no_move", no_move, 0);
    check("rst_best", {best_ene, best_plot}, 0);
    p_reset = 1'b0;
    // 1: basic four-way search
    cur = {5'd5, 5'd5};
    set_around(cur, 10'd5, 10'd3, 10'd7, 10'd9);
    run(cur, 4'b0000, 0, 0);
    check("t1_ene", best_ene, 3);
    check("t1_plot", best_plot, {5'd6, 5'd5});
    // 2: tie keeps the earlier direction; start held while busy is ignored
    set_around(cur, 10'd4, 10'd8, 10'd4, 10'd6);
    run(cur, 4'b0000, 0, 2);
    check("t2_plot", best_plot, {5'd4, 5'd5});
    check("t2_ene", best_ene, 4);
    // 3: corner with walls, nothing to read
    r = n_req;
    run(10'd0, 4'b1010, 0, 0);
    check("t3_no_req", n_req, r);
    check("t3_no_move", no_move, 1);
    // 4: slow read port
    clear_mem();
    set_around(cur, 10'd5, 10'd3, 10'd7, 10'd9);
    run(cur, 4'b0000, 3, 0);
    check("t4_plot", best_plot, {5'd6, 5'd5});
    // 5: reset while reading the down neighbour
    @(negedge m_clock);
    ack_delay = 3;
    cur_plot  = cur;
    wall_mask = 4'b0000;
    start     = 1'b1;
    @(negedge m_clock);
    start = 1'b0;
    c = 0;
    while (!(rd_req && rd_addr == {5'd6, 5'd5}) && c < 50) begin
      @(negedge m_clock);
      c++;
    end
    check("t5_req_down", rd_req && rd_addr == {5'd6, 5'd5}, 1);
    d0 = n_done;
    p_reset = 1'b1;
    @(negedge m_clock);
    check("t5_rd_req", rd_req, 0);
    check("t5_busy", busy, 0);
    p_reset = 1'b0;
    repeat (20) @(negedge m_clock);
    check("t5_no_done", n_done, d0);
    run(cur, 4'b0000, 0, 0);
    check("t5_ene", best_ene, 3);
    // 6: every neighbour unreachable
    clear_mem();
    r = n_exe;
    run(cur, 4'b0000, 0, 0);
    check("t6_no_exe", n_exe, r);
    check("t6_ene", best_ene, 0);
    // edge of grid: down/right off-grid
    set_around({5'd31, 5'd31}, 10'd20, 10'd1, 10'd10, 10'd1);
    run({5'd31, 5'd31}, 4'b0000, 1, 0);
    // random searches
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022));
      if (k == 0) begin
        set_around({5'd9, 5'd9}, 10'd7, 10'd7, 10'd7, 10'd7);
        run({5'd9, 5'd9}, 4'b0001, 0, 0);
      end else
        run(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
